// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from a circular buffer and serialises each one as
// an asynchronous UART frame (start, 8 data bits LSB-first, optional parity,
// one or two stop bits). Back-to-back frames run with no idle gap.
module uart_tx_drain #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_enable,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_data,
   output logic        fifo_rd_en,
   output logic        tx,
   output logic        busy,
   output logic [15:0] frame_count
);

   localparam logic [2:0]  ST_IDLE   = 3'd0;
   localparam logic [2:0]  ST_START  = 3'd1;
   localparam logic [2:0]  ST_DATA   = 3'd2;
   localparam logic [2:0]  ST_PARITY = 3'd3;
   localparam logic [2:0]  ST_STOP   = 3'd4;

   localparam logic [15:0] LAST_BAUD = 16'(CLKS_PER_BIT - 1);
   localparam logic        LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
   localparam logic        PAR_EN    = (PARITY_EN != 0) ? 1'b1 : 1'b0;
   localparam logic        PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

   // Parity bit as transmitted: XOR of the byte, inverted for odd parity.
   function automatic logic calc_parity(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

   logic [2:0]  state_r, state_s;
   logic [15:0] baud_r, baud_s;
   logic [2:0]  bit_idx_r, bit_idx_s;
   logic        stop_idx_r, stop_idx_s;
   logic [7:0]  shift_r, shift_s;
   logic        parity_r, parity_s;
   logic        tx_r, tx_s;
   logic        busy_r, busy_s;
   logic [15:0] frame_count_r, frame_count_s;
   logic        last_baud_s;
   logic        last_stop_s;
   logic        pop_ok_s;

   assign last_baud_s = (baud_r == LAST_BAUD);
   assign last_stop_s = (state_r == ST_STOP) && (stop_idx_r == LAST_STOP) && last_baud_s;
   // Reset also gates the pop so the buffer is never drained while held in reset.
   assign pop_ok_s    = rst_n && tx_enable && !fifo_empty &&
                        ((state_r == ST_IDLE) || last_stop_s);
   assign fifo_rd_en  = pop_ok_s;

   // Next-state, counter, shifter and frame-counter computation.
   always_comb begin
      state_s       = state_r;
      bit_idx_s     = bit_idx_r;
      stop_idx_s    = stop_idx_r;
      shift_s       = shift_r;
      parity_s      = parity_r;
      frame_count_s = frame_count_r;
      if (last_baud_s) begin
         baud_s = 16'd0;
      end else begin
         baud_s = baud_r + 16'd1;
      end
      case (state_r)
         ST_IDLE: begin
            baud_s = 16'd0;
            if (pop_ok_s) begin
               shift_s  = fifo_data;
               parity_s = calc_parity(fifo_data, PAR_ODD);
               state_s  = ST_START;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_START: begin
            if (last_baud_s) begin
               state_s   = ST_DATA;
               bit_idx_s = 3'd0;
            end else begin
               state_s   = ST_START;
            end
         end
         ST_DATA: begin
            if (last_baud_s) begin
               shift_s = {1'b0, shift_r[7:1]};
               if (bit_idx_r == 3'd7) begin
                  stop_idx_s = 1'b0;
                  state_s    = PAR_EN ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_s  = bit_idx_r + 3'd1;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (last_baud_s) begin
               stop_idx_s = 1'b0;
               state_s    = ST_STOP;
            end else begin
               state_s    = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (last_baud_s) begin
               if (stop_idx_r == LAST_STOP) begin
                  // Frame done: count it even if the next pop happens on this edge.
                  frame_count_s = frame_count_r + 16'd1;
                  if (pop_ok_s) begin
                     shift_s  = fifo_data;
                     parity_s = calc_parity(fifo_data, PAR_ODD);
                     state_s  = ST_START;
                  end else begin
                     state_s  = ST_IDLE;
                  end
               end else begin
                  stop_idx_s = stop_idx_r + 1'b1;
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            baud_s  = 16'd0;
         end
      endcase
   end

   // Line level and busy flag for the upcoming cycle, so both come out of flops.
   always_comb begin
      case (state_s)
         ST_IDLE:   tx_s = 1'b1;
         ST_START:  tx_s = 1'b0;
         ST_DATA:   tx_s = shift_s[0];
         ST_PARITY: tx_s = parity_s;
         ST_STOP:   tx_s = 1'b1;
         default:   tx_s = 1'b1;
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers; reset discards any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         baud_r        <= 16'd0;
         bit_idx_r     <= 3'd0;
         stop_idx_r    <= 1'b0;
         shift_r       <= 8'd0;
         parity_r      <= 1'b0;
         tx_r          <= 1'b1;
         busy_r        <= 1'b0;
         frame_count_r <= 16'd0;
      end else begin
         state_r       <= state_s;
         baud_r        <= baud_s;
         bit_idx_r     <= bit_idx_s;
         stop_idx_r    <= stop_idx_s;
         shift_r       <= shift_s;
         parity_r      <= parity_s;
         tx_r          <= tx_s;
         busy_r        <= busy_s;
         frame_count_r <= frame_count_s;
      end
   end

   assign tx          = tx_r;
   assign busy        = busy_r;
   assign frame_count = frame_count_r;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three instances at CLKS_PER_BIT=4 (8N1, 8E1, 8O1),
// each fed by a small behavioural buffer model. Frames are captured cycle by
// cycle and compared against hand-computed bit sequences.
module tb_uart_tx_drain;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tx_enable;
   logic        empty_v [3];
   logic [7:0]  data_v  [3];
   logic        rd_v    [3];
   logic        tx_v    [3];
   logic        busy_v  [3];
   logic [15:0] fc_v    [3];

   logic [7:0]  mem    [3][32];
   logic [5:0]  wr_ptr [3];
   logic [5:0]  rd_ptr [3] = '{6'd0, 6'd0, 6'd0};

   int n_checks = 0;
   int n_errors = 0;

   logic tx_s   [256];
   logic busy_s [256];
   logic rd_s   [256];
   int   cap_n;

   typedef struct {
      int          k;
      logic [7:0]  data;
      int          nbits;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs [7];

   always #5 clk = ~clk;

   uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_n81 (
      .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(empty_v[0]),
      .fifo_data(data_v[0]), .fifo_rd_en(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]),
      .frame_count(fc_v[0]));
   uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e81 (
      .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(empty_v[1]),
      .fifo_data(data_v[1]), .fifo_rd_en(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]),
      .frame_count(fc_v[1]));
   uart_tx_drain #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o81 (
      .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(empty_v[2]),
      .fifo_data(data_v[2]), .fifo_rd_en(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]),
      .frame_count(fc_v[2]));

   // Buffer model outputs: head byte and empty flag.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         empty_v[k] = (rd_ptr[k] == wr_ptr[k]);
         data_v[k]  = mem[k][rd_ptr[k][4:0]];
      end
   end

   // Buffer model pop on each read strobe.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rd_v[k]) rd_ptr[k] <= rd_ptr[k] + 6'd1;
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   task automatic push(input int k, input logic [7:0] b);
      mem[k][wr_ptr[k][4:0]] = b;
      wr_ptr[k] = wr_ptr[k] + 6'd1;
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic capture(input int k, input int n);
      for (int j = 0; j < n; j++) begin
         cycle();
         tx_s[j]   = tx_v[k];
         busy_s[j] = busy_v[k];
         rd_s[j]   = rd_v[k];
      end
      cap_n = n;
   endtask

   // Sample j of the capture is cycle j+off of the frame; bit b spans cycles 4b..4b+3.
   task automatic check_frame(input string nm, input logic [63:0] exp, input int nbits,
                              input int exp_rd, input int off);
      int   bad;
      int   bcnt;
      int   rcnt;
      int   c;
      logic e;
      bad = 0; bcnt = 0; rcnt = 0;
      for (int j = 0; j < cap_n; j++) begin
         c = j + off;
         e = ((c / 4) < nbits) ? exp[c / 4] : 1'b1;
         if (tx_s[j] !== e) bad++;
         if (busy_s[j] === 1'b1) bcnt++;
         if (rd_s[j] === 1'b1) rcnt++;
      end
      chk({nm, "_tx_bad_cycles"}, bad, 0);
      chk({nm, "_busy_cycles"}, bcnt, nbits * 4 - off);
      chk({nm, "_busy_after"}, int'(busy_s[nbits * 4 - off] !== 1'b0), 0);
      chk({nm, "_rd_pulses"}, rcnt, exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] fc0;
      logic [63:0] e30;
      int          bad;
      int          k;

      vecs[0] = '{0, 8'hA5, 10, 64'b1_10100101_0};
      vecs[1] = '{0, 8'h00, 10, 64'b1_00000000_0};
      vecs[2] = '{0, 8'hFF, 10, 64'b1_11111111_0};
      vecs[3] = '{1, 8'h07, 11, 64'b1_1_00000111_0};
      vecs[4] = '{2, 8'h07, 11, 64'b1_0_00000111_0};
      vecs[5] = '{1, 8'h00, 11, 64'b1_0_00000000_0};
      vecs[6] = '{2, 8'h00, 11, 64'b1_1_00000000_0};

      rst_n     = 1'b0;
      tx_enable = 1'b1;
      for (int i = 0; i < 3; i++) wr_ptr[i] = 6'd0;

      // Reset, then idle with an empty buffer.
      repeat (3) cycle();
      chk("rst_tx", int'(tx_v[0]), 1);
      chk("rst_busy", int'(busy_v[0]), 0);
      chk("rst_rd", int'(rd_v[0]), 0);
      chk("rst_fc", int'(fc_v[0]), 0);
      rst_n = 1'b1;
      bad = 0;
      for (int j = 0; j < 100; j++) begin
         cycle();
         if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rd_v[0] !== 1'b0 || fc_v[0] !== 16'd0)
            bad++;
      end
      chk("idle_bad_cycles", bad, 0);

      // Reset during DATA bit 3 discards the frame; next byte goes out cleanly.
      push(0, 8'h5A);
      push(0, 8'hC3);
      #1;
      chk("mrst_rd_first", int'(rd_v[0]), 1);
      repeat (17) cycle();
      rst_n = 1'b0;
      #1;
      chk("mrst_tx", int'(tx_v[0]), 1);
      chk("mrst_busy", int'(busy_v[0]), 0);
      chk("mrst_fc", int'(fc_v[0]), 0);
      chk("mrst_rd", int'(rd_v[0]), 0);
      repeat (3) cycle();
      rst_n = 1'b1;
      #1;
      chk("mrst_rd_next", int'(rd_v[0]), 1);
      capture(0, 44);
      check_frame("mrst_frame", 64'b1_11000011_0, 10, 0, 0);
      chk("mrst_fc_after", int'(fc_v[0]), 1);

      // Single-frame vector table across the three framings.
      for (int i = 0; i < 7; i++) begin
         k   = vecs[i].k;
         fc0 = fc_v[k];
         push(k, vecs[i].data);
         #1;
         chk($sformatf("vec%0d_rd", i), int'(rd_v[k]), 1);
         capture(k, vecs[i].nbits * 4 + 4);
         check_frame($sformatf("vec%0d", i), vecs[i].exp, vecs[i].nbits, 0, 0);
         chk($sformatf("vec%0d_fc_delta", i), int'(16'(fc_v[k] - fc0)), 1);
      end

      // Back-to-back frames with no idle gap.
      fc0 = fc_v[0];
      e30 = {34'd0, 10'b1_00111100_0, 10'b1_11111111_0, 10'b1_00000000_0};
      push(0, 8'h00);
      push(0, 8'hFF);
      push(0, 8'h3C);
      #1;
      chk("b2b_rd_first", int'(rd_v[0]), 1);
      capture(0, 124);
      check_frame("b2b", e30, 30, 2, 0);
      chk("b2b_fc_delta", int'(16'(fc_v[0] - fc0)), 3);

      // tx_enable dropped mid-frame: frame completes, no further pops.
      fc0 = fc_v[0];
      push(0, 8'h11);
      push(0, 8'h22);
      #1;
      chk("flow_rd_first", int'(rd_v[0]), 1);
      repeat (10) cycle();
      tx_enable = 1'b0;
      capture(0, 90);
      check_frame("flow", 64'b1_00010001_0, 10, 0, 10);
      chk("flow_fc_delta", int'(16'(fc_v[0] - fc0)), 1);
      tx_enable = 1'b1;
      #1;
      chk("flow_rd_resume", int'(rd_v[0]), 1);
      capture(0, 44);
      check_frame("flow_resume", 64'b1_00100010_0, 10, 0, 0);
      chk("flow_fc_delta2", int'(16'(fc_v[0] - fc0)), 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Downstream consumer of the byte circular buffer.
- Pops bytes from the buffer's empty/read_enable/read_data interface and serialises each one as an asynchronous UART frame: start bit, 8 data bits LSB-first, optional parity, stop bit(s).
- Provides flow-controlled draining of buffered bytes onto a single serial line, plus a busy flag and a frames-sent counter.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_enable  input  1  permits starting new frames; a frame in flight always completes.
- fifo_empty  input  1  buffer empty flag.
- fifo_data  input  8  buffer head byte; combinational, valid whenever fifo_empty=0.
- fifo_rd_en  output  1  pop strobe to the buffer's read_enable; combinational.
- tx  output  1  serial line; idle high.
- busy  output  1  high from the first cycle of START through the last cycle of the final stop bit.
- frame_count  output  16  frames completed; wraps at 65535 -> 0.

Behaviour:
- Reset (async, rst_n=0) forces the following, effective immediately regardless of clk:
  - state=IDLE, tx=1, busy=0, frame_count=0.
  - Bit/baud counters and shift register cleared.
  - fifo_rd_en=0.
  - A frame interrupted mid-flight is discarded; it is not retransmitted.
- States are IDLE, START, DATA, PARITY, STOP. Each non-IDLE bit period lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that runs from 0 to CLKS_PER_BIT-1.
- Define pop_ok = tx_enable && !fifo_empty && (state==IDLE || last_stop_cycle).
  - last_stop_cycle = STOP state, final stop bit, baud counter = CLKS_PER_BIT-1.
  - fifo_rd_en = pop_ok, combinational, asserted for exactly one cycle per byte.
  - On the clock edge where pop_ok=1: shift register <= fifo_data, parity register computed from fifo_data, state <= START, baud counter <= 0.
- Output per state:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0]; shift right at the end of each bit period; bit index runs 0..7, then go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = even parity (XOR of the 8 bits), inverted when PARITY_ODD=1.
  - STOP: tx=1 for STOP_BITS bit periods.
- Latency: tx falls on the first cycle after the pop edge. Frame length in cycles = (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT.
- Back-to-back frames: if pop_ok is true in last_stop_cycle, the next START begins with zero idle gap and busy stays 1.
- frame_count increments by 1 on the last_stop_cycle edge of every completed frame.
  - It increments even when a pop occurs on that same edge.
- tx_enable:
  - Deasserting it mid-frame does not truncate the frame.
  - The block returns to IDLE after the stop bit(s) and does not pop again until tx_enable=1.
- fifo_empty rising mid-frame has no effect on the frame in flight.
- Never pops while fifo_empty=1.
- Never holds more than one byte beyond the byte being transmitted; there is no internal queue.
- All outputs except fifo_rd_en are registered.

Test Plan:
- Reset then idle: rst_n low 3 cycles, fifo_empty=1, tx_enable=1 -> tx=1, busy=0, fifo_rd_en=0, frame_count=0 for 100 cycles.
- Single byte (CLKS_PER_BIT=4, 8N1):
  - Stimulus: fifo_data=0xA5, fifo_empty low for one pop.
  - fifo_rd_en is high for exactly 1 cycle.
  - tx sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - busy high for 40 cycles; frame_count=1.
- Back-to-back (CLKS_PER_BIT=4):
  - Stimulus: buffer holds 0x00, 0xFF, 0x3C.
  - Three pops, and tx shows no idle cycle between frames.
  - busy stays high for 120 consecutive cycles; frame_count=3.
- Parity (PARITY_EN=1, CLKS_PER_BIT=4):
  - Byte 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
  - Frame is 44 cycles.
- Flow control: tx_enable drops at cycle 10 of a frame with a non-empty buffer -> frame completes normally, then tx=1, no further fifo_rd_en until tx_enable returns.
- Mid-frame reset:
  - Stimulus: rst_n asserted during DATA bit 3.
  - tx=1 and busy=0 immediately, frame_count unchanged at 0.
  - After release, the next buffered byte transmits correctly.
